// File: rtl/adc_emu_pkg.sv
// ============================================================================
// Module : adc_emu_pkg
// Desc   : Shared constants and FSM encoding for the SAR ADC serial-port emulator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package adc_emu_pkg;

   localparam int CONV_CYCLES_DEF = 256;
   localparam int DATA_W_DEF      = 12;
   localparam int CFG_W_DEF       = 6;
   localparam int CONV_COUNT_W    = 16;
   localparam int TAG_W           = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CONV  = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/adc_emu_pattern_gen.sv
// ============================================================================
// Module : adc_emu_pattern_gen
// Desc   : Test-pattern ramp with a channel tag in the LSBs (ADC_EMU_PATTERN_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adc_emu_pattern_gen
   import adc_emu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              advance,
   input  logic [TAG_W-1:0]  tag,
   output logic [DATA_W-1:0] pattern
);

   logic [DATA_W-1:0] ramp;
   logic [TAG_W-1:0]  unused_ramp_lsbs;

   always_ff @(posedge clk) begin
      if (!rst_n)
         ramp <= '0;
      else if (advance)
         ramp <= ramp + DATA_W'(1);
   end

   // Pre-increment ramp value is presented; its low bits are replaced by the tag.
   assign pattern          = {ramp[DATA_W-1:TAG_W], tag};
   assign unused_ramp_lsbs = ramp[TAG_W-1:0];

endmodule

`default_nettype wire

// File: rtl/adc_emulator.sv
// ============================================================================
// Module : adc_emulator
// Desc   : Device-side loopback model of the 12-bit SAR ADC serial port.
//          Optional ramp source enabled by define ADC_EMU_PATTERN_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adc_emulator
   import adc_emu_pkg::*;
#(
   parameter int CONV_CYCLES   = CONV_CYCLES_DEF,
   parameter int DATA_W        = DATA_W_DEF,
   parameter int CFG_W         = CFG_W_DEF,
   parameter bit SDI_LSB_FIRST = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    adc_convst,
   input  logic                    adc_sck,
   input  logic                    adc_sdi,
   output logic                    adc_sdo,
   input  logic [DATA_W-1:0]       sample_in,
   output logic                    sample_req,
   input  logic                    pattern_sel,
   output logic [CFG_W-1:0]        cfg_active,
   output logic                    cfg_valid,
   output logic                    busy,
   output logic [CONV_COUNT_W-1:0] conv_count
);

   localparam int CNT_W     = cnt_width(CONV_CYCLES);
   localparam int SDI_CNT_W = cnt_width(CFG_W + 1);

   localparam logic [CNT_W-1:0]     CONV_LOAD = CNT_W'(CONV_CYCLES - 1);
   localparam logic [SDI_CNT_W-1:0] SDI_LAST  = SDI_CNT_W'(CFG_W - 1);
   localparam logic [SDI_CNT_W-1:0] SDI_FULL  = SDI_CNT_W'(CFG_W);

   logic [1:0]           state;
   logic [CNT_W-1:0]     conv_cnt;
   logic [DATA_W-1:0]    data;
   logic [SDI_CNT_W-1:0] sdi_cnt;
   logic [SDI_CNT_W-1:0] sdi_idx;
   logic [CFG_W-1:0]     cfg_pending;
   logic                 convst_q;
   logic                 sck_q;
   logic                 convst_rise;
   logic                 sck_rise;
   logic                 sck_fall;
   logic                 accept;
   logic [DATA_W-1:0]    src;

   assign convst_rise = adc_convst & ~convst_q;
   assign sck_rise    = adc_sck & ~sck_q;
   assign sck_fall    = ~adc_sck & sck_q;
   assign accept      = convst_rise && (state == ST_IDLE || state == ST_SHIFT);
   assign sdi_idx     = SDI_LSB_FIRST ? sdi_cnt : (SDI_LAST - sdi_cnt);

`ifdef ADC_EMU_PATTERN_EN
   logic [DATA_W-1:0] pattern;

   adc_emu_pattern_gen #(
      .DATA_W (DATA_W)
   ) u_pattern_gen (
      .clk     (clk),
      .rst_n   (rst_n),
      .advance (accept),
      .tag     (cfg_pending[CFG_W-1 -: TAG_W]),
      .pattern (pattern)
   );

   assign src = pattern_sel ? pattern : sample_in;
`else
   logic unused_pattern_sel;

   assign unused_pattern_sel = pattern_sel;
   assign src                = sample_in;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         conv_cnt    <= '0;
         data        <= '0;
         sdi_cnt     <= '0;
         cfg_pending <= '0;
         cfg_active  <= '0;
         convst_q    <= 1'b0;
         sck_q       <= 1'b0;
         adc_sdo     <= 1'b0;
         sample_req  <= 1'b0;
         cfg_valid   <= 1'b0;
         busy        <= 1'b0;
         conv_count  <= '0;
      end else begin
         convst_q   <= adc_convst;
         sck_q      <= adc_sck;
         sample_req <= 1'b0;
         cfg_valid  <= 1'b0;

         // A CONVST rise outranks any SCK activity in the same cycle.
         if (accept) begin
            state      <= ST_CONV;
            busy       <= 1'b1;
            conv_cnt   <= CONV_LOAD;
            cfg_active <= cfg_pending;
            data       <= src;
            sample_req <= 1'b1;
            conv_count <= conv_count + CONV_COUNT_W'(1);
            adc_sdo    <= 1'b0;
            sdi_cnt    <= '0;
         end else begin
            case (state)
               ST_CONV: begin
                  if (conv_cnt == '0) begin
                     state   <= ST_SHIFT;
                     busy    <= 1'b0;
                     adc_sdo <= data[DATA_W-1];
                  end else begin
                     conv_cnt <= conv_cnt - CNT_W'(1);
                  end
               end
               ST_SHIFT: begin
                  if (sck_fall) begin
                     data    <= {data[DATA_W-2:0], 1'b0};
                     adc_sdo <= data[DATA_W-2];
                  end
                  if (sck_rise && (sdi_cnt < SDI_FULL)) begin
                     cfg_pending[sdi_idx] <= adc_sdi;
                     sdi_cnt              <= sdi_cnt + SDI_CNT_W'(1);
                     cfg_valid            <= (sdi_cnt == SDI_LAST);
                  end
               end
               ST_IDLE: ;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_adc_emulator.sv
// ============================================================================
// Module : tb_adc_emulator
// Desc   : Self-checking bench for adc_emulator; capture-block model plus scoreboard.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_adc_emulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        adc_convst = 1'b0;
   logic        adc_sck = 1'b0;
   logic        adc_sdi = 1'b0;
   logic        pattern_sel = 1'b0;
   logic [11:0] sample_in = '0;
   wire         adc_sdo;
   wire         sample_req;
   wire         cfg_valid;
   wire         busy;
   wire  [5:0]  cfg_active;
   wire  [15:0] conv_count;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [11:0] exp_q[$];
   logic [15:0] exp_count   = '0;
   logic [5:0]  exp_pending = '0;
   logic [5:0]  exp_active  = '0;
   logic [11:0] ramp_m      = '0;

   always #5 clk = ~clk;

   adc_emulator dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .adc_convst  (adc_convst),
      .adc_sck     (adc_sck),
      .adc_sdi     (adc_sdi),
      .adc_sdo     (adc_sdo),
      .sample_in   (sample_in),
      .sample_req  (sample_req),
      .pattern_sel (pattern_sel),
      .cfg_active  (cfg_active),
      .cfg_valid   (cfg_valid),
      .busy        (busy),
      .conv_count  (conv_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_sdo"},        adc_sdo,    0);
      check({tag, "_req"},        sample_req, 0);
      check({tag, "_cfg_valid"},  cfg_valid,  0);
      check({tag, "_busy"},       busy,       0);
      check({tag, "_cfg_active"}, cfg_active, 0);
      check({tag, "_count"},      conv_count, 0);
   endtask

   // Drive a CONVST pulse (SCK forced low in the same cycle) and wait out the conversion.
   task automatic start_conv(input logic [11:0] s, input bit glitch);
      logic [11:0] e;
      int          cnt;
      @(negedge clk);
      sample_in  = s;
      adc_sck    = 1'b0;
      adc_convst = 1'b1;
      e = s;
      if (pattern_sel) e = {ramp_m[11:3], exp_pending[5:3]};
      ramp_m++;
      exp_q.push_back(e);
      exp_count++;
      exp_active = exp_pending;
      @(negedge clk);
      adc_convst = 1'b0;
      check("req_pulse",  sample_req, 1);
      check("busy_start", busy,       1);
      check("conv_count", conv_count, exp_count);
      check("cfg_active", cfg_active, exp_active);
      check("sdo_conv",   adc_sdo,    0);
      cnt = 1;
      forever begin
         @(negedge clk);
         if (!busy || cnt >= 400) break;
         cnt++;
         if (cnt == 2) check("req_single", sample_req, 0);
         if (glitch && cnt == 100) adc_convst = 1'b1;
         if (glitch && cnt == 101) adc_convst = 1'b0;
         if (glitch && cnt == 103) begin
            check("glitch_count", conv_count, exp_count);
            check("glitch_req",   sample_req, 0);
         end
      end
      check("conv_len", cnt, 256);
   endtask

   // Capture-block readout: sample SDO, raise SCK (SDI bit out), drop SCK (SDO advances).
   task automatic read_word(input int nbits, input bit send_cfg, input logic [5:0] cfg,
                            output logic [11:0] w);
      w = '0;
      for (int i = 0; i < nbits; i++) begin
         w       = {w[10:0], adc_sdo};
         adc_sck = 1'b1;
         adc_sdi = (send_cfg && i < 6) ? cfg[i] : 1'b0;
         if (i < 6) exp_pending[i] = adc_sdi;
         @(negedge clk);
         if (send_cfg && i < 7) check("cfg_valid", cfg_valid, (i == 5));
         adc_sck = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic pop_exp(output logic [11:0] e);
      if (exp_q.size() == 0) begin
         e = 'x;
         check("queue_empty", exp_q.size(), 1);
      end else begin
         e = exp_q.pop_front();
      end
   endtask

   task automatic read_check(input string tag, input bit send_cfg, input logic [5:0] cfg);
      logic [11:0] w;
      logic [11:0] e;
      read_word(12, send_cfg, cfg, w);
      pop_exp(e);
      check(tag, w, e);
      check({tag, "_tail"}, adc_sdo, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL timeout: simulation did not finish (got no end, expected end)");
      $fatal(1);
   end

   initial begin
      logic [11:0] w;
      logic [11:0] e;

      repeat (3) @(negedge clk);
      check_reset("reset");
      rst_n = 1'b1;

      // Basic conversion with config word 1,0,1,1,0,0 sent on the first six rises.
      start_conv(12'hA5C, 1'b0);
      read_check("t1_data", 1'b1, 6'b001101);
      check("t1_count", conv_count, 1);
      check("t2_cfg_hold", cfg_active, 0);

      // Config takes effect here; a CONVST mid-conversion is ignored.
      start_conv(12'h3C7, 1'b1);
      check("t2_cfg_applied", cfg_active, 6'b001101);
      read_check("t3_data", 1'b0, 6'b0);

      // Short readout then a new conversion.
      start_conv(12'h111, 1'b0);
      read_word(5, 1'b0, 6'b0, w);
      pop_exp(e);
      check("t4_partial", w[4:0], e[11:7]);
      start_conv(12'h9AB, 1'b0);
      check("t4_msb", adc_sdo, 1);
      read_check("t4_data", 1'b0, 6'b0);

      // SCK fall coinciding with a CONVST rise: the conversion starts.
      start_conv(12'h6D2, 1'b0);
      read_word(2, 1'b0, 6'b0, w);
      pop_exp(e);
      check("t6_partial", w[1:0], e[11:10]);
      adc_sdi = 1'b0;
      adc_sck = 1'b1;
      exp_pending[2] = 1'b0;
      @(negedge clk);
      start_conv(12'h2B4, 1'b0);
      read_check("t6_data", 1'b0, 6'b0);

      // Reset pulse in the middle of a readout.
      start_conv(12'h555, 1'b0);
      read_word(3, 1'b0, 6'b0, w);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset("t5_reset");
      exp_q.delete();
      exp_count   = '0;
      exp_pending = '0;
      ramp_m      = '0;
      start_conv(12'h0F0, 1'b0);
      read_check("t5_data", 1'b1, 6'b101000);
      check("t5_count", conv_count, 1);

`ifdef ADC_EMU_PATTERN_EN
      pattern_sel = 1'b1;
      for (int k = 0; k < 3; k++) begin
         start_conv(12'hFFF, 1'b0);
         read_check("pattern_data", 1'b1, 6'b101000);
      end
      pattern_sel = 1'b0;
`endif

      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
